// File: rtl/compressed_line_out_buffer_pkg.sv
// Shared types and default sizing for the compressed-line output buffer.
package comp_out_pkg;
  localparam int CACHE_LINE = 128;
  localparam int DEPTH      = 8;
  localparam int AF_MARGIN  = 2;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                  raw;
    logic [CACHE_LINE-1:0] line;
  } out_entry_t;
endpackage

// File: rtl/compressed_line_out_buffer_if.sv
// Line-in / head-out bus of the compressed-line output buffer.
// OUT_BUFFER_STATS_EN adds the line statistics counters.
interface compressed_line_out_buffer_if
  import comp_out_pkg::*;
#(
  parameter int CNT_W = comp_out_pkg::CNT_W
);
  logic [CACHE_LINE-1:0] i_line;
  logic                  i_line_valid;
  logic                  i_raw;
  logic                  i_flush;
  logic                  o_almost_full;
  logic                  o_overflow;
  logic [CNT_W-1:0]      o_count;
  logic [CACHE_LINE-1:0] o_data;
  logic                  o_raw;
  logic                  o_valid;
  logic                  i_ready;
`ifdef OUT_BUFFER_STATS_EN
  logic [31:0]           o_lines_total;
  logic [31:0]           o_lines_raw;
`endif

  modport slave (
    input  i_line, i_line_valid, i_raw, i_flush, i_ready,
`ifdef OUT_BUFFER_STATS_EN
    output o_lines_total, o_lines_raw,
`endif
    output o_almost_full, o_overflow, o_count, o_data, o_raw, o_valid
  );

  modport master (
    output i_line, i_line_valid, i_raw, i_flush, i_ready,
`ifdef OUT_BUFFER_STATS_EN
    input  o_lines_total, o_lines_raw,
`endif
    input  o_almost_full, o_overflow, o_count, o_data, o_raw, o_valid
  );
endinterface

// File: rtl/compressed_line_out_buffer_mem.sv
// Entry storage for the output buffer: one write port, one asynchronous read port.
module out_buffer_mem
  import comp_out_pkg::*;
#(
  parameter int DEPTH = comp_out_pkg::DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  out_entry_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output out_entry_t    o_rdata
);
  out_entry_t mem_q [DEPTH];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/compressed_line_out_buffer.sv
// First-word-fall-through queue of tagged compressed lines with almost-full backpressure.
// OUT_BUFFER_STATS_EN adds saturating total/raw line counters.
module compressed_line_out_buffer
  import comp_out_pkg::*;
#(
  parameter int DEPTH     = comp_out_pkg::DEPTH,
  parameter int AF_MARGIN = comp_out_pkg::AF_MARGIN
) (
  input logic                         i_clk,
  input logic                         i_reset,
  compressed_line_out_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          valid_s, full_s, pop_s, push_s;
  out_entry_t    wdata_s, rdata_s;

  assign valid_s = (count_q != '0);
  assign full_s  = (count_q == FULL_CNT);
  assign pop_s   = valid_s & bus.i_ready;
  assign push_s  = bus.i_line_valid & (~full_s | pop_s);
  assign wdata_s = '{raw: bus.i_raw, line: bus.i_line};

  // Pointer, occupancy and overflow next state; flush overrides push and pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.i_line_valid && !push_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  out_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .i_clk   (i_clk),
    .i_we    (push_s & ~bus.i_flush),
    .i_waddr (wr_ptr_q),
    .i_wdata (wdata_s),
    .i_raddr (rd_ptr_q),
    .o_rdata (rdata_s)
  );

  // Head is forced to zero while empty so stale storage never shows after reset.
  assign bus.o_data        = valid_s ? rdata_s.line : '0;
  assign bus.o_raw         = valid_s & rdata_s.raw;
  assign bus.o_valid       = valid_s;
  assign bus.o_count       = count_q;
  assign bus.o_almost_full = (count_q >= AF_CNT);
  assign bus.o_overflow    = overflow_q;

`ifdef OUT_BUFFER_STATS_EN
  logic [31:0] total_q, total_d, raw_q, raw_d;
  logic        accept_s;

  assign accept_s = push_s & ~bus.i_flush;

  // Saturating counts of accepted lines; only reset clears them.
  always_comb begin
    total_d = total_q;
    raw_d   = raw_q;
    if (accept_s && (total_q != 32'hFFFF_FFFF)) begin
      total_d = total_q + 32'd1;
    end else begin
      total_d = total_q;
    end
    if (accept_s && bus.i_raw && (raw_q != 32'hFFFF_FFFF)) begin
      raw_d = raw_q + 32'd1;
    end else begin
      raw_d = raw_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      total_q <= 32'd0;
      raw_q   <= 32'd0;
    end else begin
      total_q <= total_d;
      raw_q   <= raw_d;
    end
  end

  assign bus.o_lines_total = total_q;
  assign bus.o_lines_raw   = raw_q;
`endif
endmodule
